clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Parametrised multi-channel automatic clock-gating controller. One idle-detection state machine and one latch-based glitch-free clock gate per channel. A channel's gated clock is stopped after its activity input has been low for a programmable number of cycles, and restarted on demand. Sits at the clock-distribution boundary between the core clock and the per-unit clock domains; a scan test enable overrides all gating.

## Interface
Parameters:
- NCH, default 4: number of gated channels (1..32).
- CNTW, default 8: width of each idle threshold and idle counter.

Ports:
- CP: input, 1 bit. Free-running source clock; all state advances on its rising edge.
- CDN: input, 1 bit. Reset; asynchronous, active-low.
- TE: input, 1 bit. Scan/test enable. When 1, every Q[c] follows CP.
- EN: input, NCH bits. Per-channel auto-gating enable. 0 means the channel clock always runs.
- BUSY: input, NCH bits. Per-channel activity/wake request, synchronous to CP.
- THR: input, NCH*CNTW bits. Idle threshold for channel c is THR[c*CNTW +: CNTW]; value in cycles.
- Q: output, NCH bits. Gated clocks.
- STS: output, NCH bits. Registered gate enable; 1 means the channel clock is enabled.

## Operation
- Per-channel FSM states: ON, IDLE, OFF. Per-channel counter cnt, CNTW bits wide.
- Define idle_ok = EN[c] & ~BUSY[c].
- Transitions, each evaluated at the CP rising edge:
  - ON: if idle_ok and THR==0, go to OFF. If idle_ok and THR!=0, go to IDLE with cnt=0. Otherwise stay in ON.
  - IDLE: if !idle_ok, go to ON with cnt=0. Else if cnt >= THR-1 (or THR==0), go to OFF. Else cnt <= cnt+1.
  - OFF: if !idle_ok, go to ON. Otherwise stay in OFF.
- THR is sampled live every cycle. Lowering THR mid-count below the current cnt sends the channel to OFF at the next edge. cnt never wraps.
- Gate enable register: ge[c] <= (next state != OFF). STS = ge.
- Gate cell, per channel:
  - The latch is transparent while CP is low. Latch input is ge[c] | TE.
  - Q[c] = latch[c] & CP.
  - The latch must not change while CP is high.
- TE does not alter FSM state, cnt or STS. It only forces the latch input to 1.
- Reset (CDN=0), applied immediately:
  - State = ON, cnt = 0, ge = all ones, STS = all ones.
  - The latch is not asynchronously set. It takes ge in the next CP-low phase, so no partial Q pulse is generated.
  - The latch power-up value is undefined until the first CP-low phase after CDN falls. CDN must therefore be held low for at least one full CP period.
- Channels are fully independent. There is no shared arbitration.

## Timing
- Gate-off latency: BUSY[c] falls before edge k while EN=1 and THR=T (T>0).
  - IDLE is entered at edge k; OFF at edge k+T; STS falls after edge k+T.
  - The last Q pulse is the high phase beginning at edge k+T.
  - The first suppressed pulse is at edge k+T+1.
- THR=0: OFF at edge k; the first suppressed Q pulse is at edge k+1.
- Wake latency: BUSY[c] rises before edge m while in OFF.
  - State is ON at edge m; STS rises after edge m.
  - The latch opens in the low phase of cycle m; the first Q pulse is at edge m+1.
  - Consumers must hold their request for one cycle after STS rises.
- BUSY rising in the same cycle that cnt reaches THR-1: BUSY wins, the state goes to ON, and no pulse is lost.
- EN falling in any state: ON at the next edge; same wake latency as BUSY.
- TE rising: takes effect in the next CP-low phase. Q runs from the following rising edge regardless of STS.
- Q is glitch-free for any BUSY/EN/TE/THR change that meets setup to the CP rising edge.

## Test plan
- Reset with CP running, NCH=4: STS=4'hF at CDN release. All Q toggle with CP. No runt pulse while CDN is asserted during a CP-high phase.
- EN[0]=1, THR[0]=3, BUSY[0] falls before edge 10: Q[0] pulses at edges 10–13, no pulse at edge 14. STS[0] falls after edge 13. Other channels (EN=0) keep toggling.
- Channel 0 in OFF, BUSY[0] raised before edge 20: STS[0]=1 after edge 20, first Q[0] pulse at edge 21. The next drop of BUSY restarts cnt from 0.
- THR[1]=10, BUSY[1] low for 9 cycles then high for 1 cycle then low again: channel never reaches OFF during the first 9 cycles. cnt restarts, and OFF occurs exactly 10 edges after the second fall.
- All channels OFF, TE=1 for 5 cycles: all Q toggle from the edge after the next CP-low phase. STS stays 0 throughout, and gating resumes immediately after TE=0.
- THR[2] changed from 200 to 2 while cnt=50: channel 2 goes to OFF at the next edge.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: multi-channel automatic clock-gating controller.
// Each channel runs an idle-detection FSM (ON -> IDLE -> OFF) clocked by CP
// and drives a latch-based glitch-free clock gate. A channel's gated clock
// stops after its activity input has been idle for THR cycles and restarts
// as soon as activity (or a disabled auto-gate) is seen. TE forces every
// gate open for scan without disturbing the FSMs.
module clk_gate_ctrl #(
  parameter int NCH  = 4,
  parameter int CNTW = 8
) (
  input  logic                 CP,
  input  logic                 CDN,
  input  logic                 TE,
  input  logic [NCH-1:0]       EN,
  input  logic [NCH-1:0]       BUSY,
  input  logic [NCH*CNTW-1:0]  THR,
  output logic [NCH-1:0]       Q,
  output logic [NCH-1:0]       STS
);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] thr;
    logic            idle_ok;
    logic            ge_q, ge_d;
    logic            en_lat;

    // THR is sampled live every cycle, so a lowered threshold acts at once.
    assign thr     = THR[c*CNTW +: CNTW];
    assign idle_ok = EN[c] & ~BUSY[c];

    // Next-state and counter logic for the idle-detection FSM.
    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first, so no latch is inferred and the block reads top to bottom.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_ON: begin
          if (idle_ok) begin
            if (thr == '0) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
        end
        ST_IDLE: begin
          if (!idle_ok) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if ((thr == '0) || (cnt_q >= (thr - CNT_ONE))) begin
            state_d = ST_OFF;
          end else begin
            // Only reached while cnt_q < thr-1, so the counter cannot wrap.
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_OFF: begin
          if (!idle_ok) begin
            state_d = ST_ON;
          end
        end
        default: begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      endcase
      ge_d = (state_d != ST_OFF);
    end

    // State, counter and registered gate enable; reset leaves the clock running.
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge CP or negedge CDN) begin
      if (!CDN) begin
        state_q <= ST_ON;
        cnt_q   <= '0;
        ge_q    <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ge_q    <= ge_d;
      end
    end

    // Gate latch: transparent while CP is low, frozen while CP is high.
    // NOTE: this latch is intentional and has no reset; it picks up ge_q
    // (forced to 1 by reset) in the first CP-low phase, so no runt pulse
    // can appear on Q while reset is asserted during a CP-high phase.
    always_latch begin
      if (!CP) begin
        en_lat <= ge_q | TE;
      end
    end

    assign Q[c]   = en_lat & CP;
    assign STS[c] = ge_q;
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl. The reference model tracks, per
// channel, how many consecutive edges the channel has been idle; a channel
// is off once that run exceeds its live threshold and stays off until the
// run is broken. Q is expected high during a CP-high phase when the previous
// gate enable or TE was 1.
module tb_clk_gate_ctrl;
  localparam int NCH  = 4;
  localparam int CNTW = 8;

  logic                CP   = 1'b0;
  logic                CDN  = 1'b1;
  logic                TE   = 1'b0;
  logic [NCH-1:0]      EN   = '0;
  logic [NCH-1:0]      BUSY = '0;
  logic [NCH*CNTW-1:0] THR  = '0;
  logic [NCH-1:0]      Q;
  logic [NCH-1:0]      STS;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int             run_m [NCH];
  bit             off_m [NCH];
  logic [NCH-1:0] sts_m;
  logic [NCH-1:0] exp_q;

  clk_gate_ctrl #(.NCH(NCH), .CNTW(CNTW)) dut (
    .CP  (CP),
    .CDN (CDN),
    .TE  (TE),
    .EN  (EN),
    .BUSY(BUSY),
    .THR (THR),
    .Q   (Q),
    .STS (STS)
  );

  always #5 CP = ~CP;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_thr(input int c, input int v);
    THR[c*CNTW +: CNTW] = CNTW'(v);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      run_m[c] = 0;
      off_m[c] = 1'b0;
    end
    sts_m = '1;
  endtask

  // Advance to the next rising edge, update the model with the inputs seen
  // at that edge, and return 1 time unit later (inside the CP-high phase).
  task automatic tick();
    @(posedge CP);
    exp_q = sts_m | {NCH{TE}};
    if (!CDN) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit idle;
        int thr;
        idle = EN[c] & ~BUSY[c];
        thr  = int'(THR[c*CNTW +: CNTW]);
        run_m[c] = idle ? run_m[c] + 1 : 0;
        off_m[c] = idle && (off_m[c] || (run_m[c] >= thr + 1));
        sts_m[c] = ~off_m[c];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    CDN = 1'b1;
    #1;
    CDN = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (STS !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_sts cyc %0d: got %b want 1111", i, STS);
      end
      n_tests++;
      if (Q !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_q cyc %0d: got %b want 1111", i, Q);
      end
    end
    CDN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (STS !== 4'hF || Q !== 4'hF) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got sts %b q %b want 1111/1111", i, STS, Q);
      end
    end
    // Gate everything off, then assert reset in the middle of a CP-high phase.
    EN = '1;
    BUSY = '0;
    THR = '0;
    tick();
    tick();
    n_tests++;
    if (Q !== 4'h0 || STS !== 4'h0) begin
      n_fail++;
      $display("FAIL all_off: got q %b sts %b want 0000/0000", Q, STS);
    end
    CDN = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (Q !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_runt: got q %b want 0000", Q);
    end
    n_tests++;
    if (STS !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_async_sts: got %b want 1111", STS);
    end
    EN = '0;
    tick();
    n_tests++;
    if (Q !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_resume_q: got %b want 1111", Q);
    end
    CDN = 1'b1;
    tick();
  endtask

  task automatic test_gate_off();
    EN = 4'b0001;
    BUSY = 4'b0001;
    set_thr(0, 3);
    tick();
    tick();
    BUSY[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (Q[0] !== (i <= 3)) begin
        n_fail++;
        $display("FAIL gate_off_q0 edge %0d: got %b want %b", i, Q[0], (i <= 3));
      end
      n_tests++;
      if (STS[0] !== (i < 3)) begin
        n_fail++;
        $display("FAIL gate_off_sts0 edge %0d: got %b want %b", i, STS[0], (i < 3));
      end
      n_tests++;
      if (Q[3:1] !== 3'b111 || STS !== sts_m) begin
        n_fail++;
        $display("FAIL gate_off_others edge %0d: got q %b sts %b want q[3:1] 111 sts %b",
                 i, Q, STS, sts_m);
      end
    end
  endtask

  task automatic test_wake();
    BUSY[0] = 1'b1;
    tick();
    n_tests++;
    if (STS[0] !== 1'b1 || Q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_edge_m: got sts0 %b q0 %b want 1/0", STS[0], Q[0]);
    end
    tick();
    n_tests++;
    if (Q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_first_pulse: got %b want 1", Q[0]);
    end
    BUSY[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (STS[0] !== (i < 3) || Q !== exp_q) begin
        n_fail++;
        $display("FAIL wake_regate edge %0d: got sts0 %b q %b want sts0 %b q %b",
                 i, STS[0], Q, (i < 3), exp_q);
      end
    end
  endtask

  task automatic test_busy_glitch();
    EN = 4'b0010;
    BUSY = 4'b0010;
    set_thr(1, 10);
    tick();
    BUSY[1] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++;
      if (STS[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL glitch_first_run edge %0d: got %b want 1", i, STS[1]);
      end
    end
    BUSY[1] = 1'b1;
    tick();
    n_tests++;
    if (STS[1] !== 1'b1 || Q[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: got sts1 %b q1 %b want 1/1", STS[1], Q[1]);
    end
    BUSY[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (STS[1] !== (i < 10) || STS !== sts_m || Q !== exp_q) begin
        n_fail++;
        $display("FAIL glitch_second_run edge %0d: got sts %b q %b want sts %b q %b",
                 i, STS, Q, sts_m, exp_q);
      end
    end
  endtask

  task automatic test_te();
    EN = '1;
    BUSY = '0;
    THR = '0;
    tick();
    tick();
    TE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (Q !== 4'hF || STS !== 4'h0) begin
        n_fail++;
        $display("FAIL te_override cyc %0d: got q %b sts %b want 1111/0000", i, Q, STS);
      end
    end
    TE = 1'b0;
    tick();
    n_tests++;
    if (Q !== 4'h0 || STS !== 4'h0) begin
      n_fail++;
      $display("FAIL te_release: got q %b sts %b want 0000/0000", Q, STS);
    end
  endtask

  task automatic test_thr_change();
    EN = 4'b0100;
    BUSY = 4'b0100;
    set_thr(2, 200);
    tick();
    BUSY[2] = 1'b0;
    for (int i = 0; i < 51; i++) tick();
    n_tests++;
    if (STS[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_mid_count: got %b want 1", STS[2]);
    end
    set_thr(2, 2);
    tick();
    n_tests++;
    if (STS[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_lowered: got %b want 0", STS[2]);
    end
    tick();
    n_tests++;
    if (Q[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_lowered_q: got %b want 0", Q[2]);
    end
  endtask

  task automatic test_random();
    EN = '1;
    BUSY = '0;
    TE = 1'b0;
    for (int c = 0; c < NCH; c++) set_thr(c, $urandom_range(0, 6));
    for (int i = 0; i < 600; i++) begin
      tick();
      n_tests++;
      if (STS !== sts_m) begin
        n_fail++;
        $display("FAIL rand_sts cyc %0d: got %b want %b", i, STS, sts_m);
      end
      n_tests++;
      if (Q !== exp_q) begin
        n_fail++;
        $display("FAIL rand_q_high cyc %0d: got %b want %b", i, Q, exp_q);
      end
      @(negedge CP);
      #1;
      n_tests++;
      if (Q !== 4'h0) begin
        n_fail++;
        $display("FAIL rand_q_low cyc %0d: got %b want 0000", i, Q);
      end
      for (int c = 0; c < NCH; c++) begin
        BUSY[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 29) == 0) EN[c] = ~EN[c];
        if ($urandom_range(0, 19) == 0) set_thr(c, $urandom_range(0, 8));
      end
      TE = ($urandom_range(0, 15) == 0);
    end
    TE = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_gate_off();
    test_wake();
    test_busy_glitch();
    test_te();
    test_thr_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
